// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader: the two-state control machine.
package fifo_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains an upstream FIFO read port in bursts of up to BurstLen words through
// a single output register, with flush and idle-timeout forcing of partial bursts.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int Width    = 16,
  parameter int Depth    = 4,
  parameter int BurstLen = 4,
  parameter int Timeout  = 8,
  localparam int DepthW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_rvalid_i,
  output logic              fifo_rready_o,
  input  logic [Width-1:0]  fifo_rdata_i,
  input  logic [DepthW-1:0] fifo_rdepth_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [Width-1:0]  out_data_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int RemW = $clog2(BurstLen + 1);
  localparam int TimW = $clog2(Timeout + 1);

  localparam logic [DepthW-1:0] BurstDepth = DepthW'(BurstLen);
  localparam logic [RemW-1:0]   BurstRem   = RemW'(BurstLen);
  localparam logic [RemW-1:0]   RemOne     = RemW'(1);
  localparam logic [TimW-1:0]   TimeoutVal = TimW'(Timeout);

  generate
    if (BurstLen < 1 || BurstLen > Depth || Timeout < 1) begin : g_bad_params
      $error("fifo_burst_reader: need 1 <= BurstLen <= Depth and Timeout >= 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [RemW-1:0]   remaining_q, remaining_d;
  logic [TimW-1:0]   timer_q, timer_d;
  logic              first_pend_q, first_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [Width-1:0]  out_data_q, out_data_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;

  logic              rready;
  logic              pop;
  logic              start_full;
  logic              start_forced;
  logic [RemW-1:0]   partial_len;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    timer_d      = timer_q;
    first_pend_d = first_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;

    rready       = (state_q == BURST) && (!out_valid_q || out_ready_i);
    pop          = fifo_rvalid_i && rready;
    start_full   = (fifo_rdepth_i >= BurstDepth);
    start_forced = !start_full && (flush_i || (timer_q == TimeoutVal)) && fifo_rvalid_i;

    // Occupancy may lag rvalid on an async FIFO, so a zero depth still moves one word.
    if (fifo_rdepth_i == '0) begin
      partial_len = RemOne;
    end else begin
      partial_len = RemW'(fifo_rdepth_i);
    end

    case (state_q)
      IDLE: begin
        if (start_full) begin
          state_d      = BURST;
          remaining_d  = BurstRem;
          timer_d      = '0;
          first_pend_d = 1'b1;
        end else if (start_forced) begin
          state_d      = BURST;
          remaining_d  = partial_len;
          timer_d      = '0;
          first_pend_d = 1'b1;
        end else if (!fifo_rvalid_i) begin
          timer_d = '0;
        end else if (timer_q != TimeoutVal) begin
          timer_d = timer_q + 1'b1;
        end
      end
      BURST: begin
        timer_d = '0;
        if (pop) begin
          remaining_d  = remaining_q - 1'b1;
          first_pend_d = 1'b0;
          if (remaining_q == RemOne) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop overwrites the register even while its current beat is being taken.
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rdata_i;
      out_first_d = first_pend_q;
      out_last_d  = (remaining_q == RemOne);
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      timer_q      <= '0;
      first_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      timer_q      <= timer_d;
      first_pend_q <= first_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
    end
  end

  assign fifo_rready_o = rready;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_first_o   = out_first_q;
  assign out_last_o    = out_last_q;
  assign busy_o        = (state_q == BURST) || out_valid_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: an upstream FIFO model, a beat scoreboard, directed
// scenarios with cycle-exact expectations, then a randomized soak.
module tb_fifo_burst_reader;

  localparam int Width    = 16;
  localparam int Depth    = 4;
  localparam int BurstLen = 4;
  localparam int Timeout  = 8;
  localparam int DepthW   = $clog2(Depth + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              fifo_rvalid_i;
  logic              fifo_rready_o;
  logic [Width-1:0]  fifo_rdata_i;
  logic [DepthW-1:0] fifo_rdepth_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [Width-1:0]  out_data_o;
  logic              out_first_o;
  logic              out_last_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  fifo_burst_reader #(
    .Width(Width), .Depth(Depth), .BurstLen(BurstLen), .Timeout(Timeout)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fifo_rvalid_i(fifo_rvalid_i), .fifo_rready_o(fifo_rready_o),
    .fifo_rdata_i(fifo_rdata_i), .fifo_rdepth_i(fifo_rdepth_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_first_o(out_first_o), .out_last_o(out_last_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [Width-1:0] data;
    logic             first;
    logic             last;
    int               cyc;
  } beat_t;

  logic [Width-1:0] fifo_q[$];
  logic [Width-1:0] exp_q[$];
  beat_t            beats[$];
  beat_t            want_beats[$];
  int               pop_cyc[$];
  int               want_pops[$];

  int               cyc;
  int               n_assert;
  int               n_fail;
  int               n_rdy;
  int               t0;
  int               n_pushed;
  bit               in_burst;
  int               blen;
  bit               prev_stall;
  logic [Width-1:0] prev_data;
  logic [1:0]       prev_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_rvalid_i = (fifo_q.size() > 0);
    fifo_rdata_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    fifo_rdepth_i = DepthW'(fifo_q.size());
  endtask

  task automatic push(input logic [Width-1:0] w);
    fifo_q.push_back(w);
    n_pushed++;
    drive_fifo();
  endtask

  task automatic start_scn();
    pop_cyc.delete();
    beats.delete();
    want_pops.delete();
    want_beats.delete();
    n_rdy = 0;
    t0 = cyc;
  endtask

  task automatic want_beat(input logic [Width-1:0] d, input logic f, input logic l, input int c);
    beat_t b;
    b.data = d; b.first = f; b.last = l; b.cyc = c;
    want_beats.push_back(b);
  endtask

  // One clock: sample at the falling edge, then let the FIFO model react to the pop.
  task automatic tick();
    bit    do_pop;
    bit    do_acc;
    beat_t b;
    @(negedge clk_i);
    if (prev_stall) begin
      chk("hold_data", out_data_o, prev_data);
      chk("hold_flags", {out_first_o, out_last_o}, prev_flags);
    end
    do_pop = fifo_rvalid_i && fifo_rready_o;
    do_acc = out_valid_o && out_ready_i;
    if (fifo_rready_o) n_rdy++;
    if (do_pop) pop_cyc.push_back(cyc);
    if (do_acc) begin
      b.data = out_data_o; b.first = out_first_o; b.last = out_last_o; b.cyc = cyc;
      beats.push_back(b);
      $display("beat cyc=%0d data=0x%04h first=%0d last=%0d", cyc, out_data_o, out_first_o, out_last_o);
      chk("beat_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat_data", out_data_o, exp_q.pop_front());
      if (out_first_o) begin
        chk("burst_start_clean", in_burst, 0);
        in_burst = 1'b1;
        blen = 0;
      end else begin
        chk("burst_cont", in_burst, 1);
      end
      blen++;
      chk("burst_len_ok", blen <= BurstLen, 1);
      if (out_last_o) in_burst = 1'b0;
    end
    prev_stall = out_valid_o && !out_ready_i;
    prev_data  = out_data_o;
    prev_flags = {out_first_o, out_last_o};
    @(posedge clk_i);
    #1;
    if (do_pop) begin
      exp_q.push_back(fifo_q.pop_front());
      drive_fifo();
    end
    cyc++;
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_npops"}, pop_cyc.size(), want_pops.size());
    for (int i = 0; i < pop_cyc.size() && i < want_pops.size(); i++)
      chk({tag, "_pop_cyc"}, pop_cyc[i], want_pops[i]);
    chk({tag, "_nbeats"}, beats.size(), want_beats.size());
    for (int i = 0; i < beats.size() && i < want_beats.size(); i++) begin
      chk({tag, "_data"}, beats[i].data, want_beats[i].data);
      chk({tag, "_first"}, beats[i].first, want_beats[i].first);
      chk({tag, "_last"}, beats[i].last, want_beats[i].last);
      chk({tag, "_beat_cyc"}, beats[i].cyc, want_beats[i].cyc);
    end
    chk({tag, "_no_leftover"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_data"}, out_data_o, 0);
    chk({tag, "_first"}, out_first_o, 0);
    chk({tag, "_last"}, out_last_o, 0);
    chk({tag, "_rready"}, fifo_rready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    cyc = 0; n_assert = 0; n_fail = 0; n_pushed = 0;
    in_burst = 1'b0; blen = 0; prev_stall = 1'b0;
    prev_data = '0; prev_flags = '0;
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    drive_fifo();
    #12;
    check_all_zero("reset");
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Full burst of four words.
    start_scn();
    for (int i = 0; i < 4; i++) push(16'h000A + 16'(i));
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      want_pops.push_back(t0 + 1 + i);
      want_beat(16'h000A + 16'(i), i == 0, i == 3, t0 + 2 + i);
    end
    check_logs("full");
    chk("full_rready_cycles", n_rdy, 4);
    chk("full_idle_after", busy_o, 0);

    // A lone word is forced out after the idle timeout.
    start_scn();
    push(16'h1234);
    repeat (12) tick();
    want_pops.push_back(t0 + 9);
    want_beat(16'h1234, 1'b1, 1'b1, t0 + 10);
    check_logs("timeout");

    // Backpressure after the second beat for five cycles.
    start_scn();
    for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
    repeat (4) tick();
    out_ready_i = 1'b0;
    repeat (5) tick();
    out_ready_i = 1'b1;
    repeat (4) tick();
    want_pops.push_back(t0 + 1);
    want_pops.push_back(t0 + 2);
    want_pops.push_back(t0 + 3);
    want_pops.push_back(t0 + 9);
    want_beat(16'h0040, 1'b1, 1'b0, t0 + 2);
    want_beat(16'h0041, 1'b0, 1'b0, t0 + 3);
    want_beat(16'h0042, 1'b0, 1'b0, t0 + 9);
    want_beat(16'h0043, 1'b0, 1'b1, t0 + 10);
    check_logs("bp");

    // Flush with two words, then a fresh word needs the whole timeout again.
    start_scn();
    push(16'h0051);
    push(16'h0052);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (5) tick();
    want_pops.push_back(t0 + 1);
    want_pops.push_back(t0 + 2);
    want_beat(16'h0051, 1'b1, 1'b0, t0 + 2);
    want_beat(16'h0052, 1'b0, 1'b1, t0 + 3);
    check_logs("flush");
    start_scn();
    push(16'h0053);
    repeat (12) tick();
    want_pops.push_back(t0 + 9);
    want_beat(16'h0053, 1'b1, 1'b1, t0 + 10);
    check_logs("post_flush_timer");

    // Depth reaches four while the timer reads seven: a full burst, not a partial one.
    start_scn();
    push(16'h0061);
    repeat (7) tick();
    push(16'h0062);
    push(16'h0063);
    push(16'h0064);
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      want_pops.push_back(t0 + 8 + i);
      want_beat(16'h0061 + 16'(i), i == 0, i == 3, t0 + 9 + i);
    end
    check_logs("near_timeout");

    // Reset after two pops; the rest of the FIFO drains as a fresh partial burst.
    start_scn();
    for (int i = 0; i < 4; i++) push(16'h0071 + 16'(i));
    repeat (3) tick();
    chk("rst_pops_before", pop_cyc.size(), 2);
    rst_i = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    in_burst = 1'b0;
    prev_stall = 1'b0;
    #1 rst_i = 1'b0;
    chk("rst_fifo_kept", fifo_q.size(), 2);
    start_scn();
    repeat (14) tick();
    want_pops.push_back(t0 + 9);
    want_pops.push_back(t0 + 10);
    want_beat(16'h0073, 1'b1, 1'b0, t0 + 10);
    want_beat(16'h0074, 1'b0, 1'b1, t0 + 11);
    check_logs("after_rst");

    // Randomized soak, then drain; the scoreboard checks order, framing and holds.
    start_scn();
    n_pushed = 0;
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < Depth && $urandom_range(0, 2) != 0)
        push(16'($urandom));
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (40) tick();
    chk("rand_fifo_empty", fifo_q.size(), 0);
    chk("rand_no_leftover", exp_q.size(), 0);
    chk("rand_all_delivered", beats.size(), n_pushed);
    chk("rand_burst_closed", in_burst, 0);
    chk("rand_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
